mmio_console_ctrl: RTL and testbench

Console/finish controller on the data-bus MMIO window (address bit 31 set). Buffers bytes written by the CPU, serializes them on a UART TX line, and raises a sticky finish flag once the finish code is written and all buffered output has drained. Sits beside the CPU dbus in `main`. It replaces direct testbench `$write` printing with synthesizable console output and an orderly end-of-run signal.

---
 rtl/mmio_console_ctrl.sv | 158 +++++++++++++++
 tb/tb_mmio_console_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console_ctrl.sv
`timescale 1ns/1ps
// MMIO console/finish controller: buffers CPU store bytes, shifts them out as 8N1 UART,
// and raises a sticky finish flag once the finish code is seen and all output has drained.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit, line low
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high; chains straight into START when more bytes wait
module mmio_console_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 1_000_000,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] FINI_CODE   = 32'h0002_0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_wvalid_i,
  input  logic [31:0] dbus_wdata_i,
  output logic        stall_o,
  output logic        txd_o,
  output logic        busy_o,
  output logic        fini_o
);
  localparam int unsigned BIT_CYC = CLK_FREQ_HZ / BAUD;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned TMR_W   = $clog2(BIT_CYC);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             fini_pend_q, fini_pend_d;
  logic             fini_q, fini_d;

  logic sel, is_fini, full, fifo_ne, take_byte, push, pop, bit_end;
  logic unused_addr;

  assign unused_addr = ^dbus_addr_i[30:0];
  assign fini_o      = fini_q;

  // Fullness uses the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    sel         = dbus_addr_i[31] & dbus_wvalid_i;
    is_fini     = (dbus_wdata_i == FINI_CODE);
    full        = (count_q == DEPTH_C);
    fifo_ne     = (count_q != '0);
    take_byte   = sel & ~is_fini & ~fini_pend_q;
    stall_o     = take_byte & full;
    push        = take_byte & ~full;
    busy_o      = fifo_ne | (state_q != ST_IDLE);
    fini_pend_d = fini_pend_q | (sel & is_fini);
    fini_d      = fini_q | (fini_pend_q & ~busy_o);
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    txd_o     = 1'b1;
    bit_end   = (tmr_q == TMR_LAST);
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (fifo_ne) begin
          pop     = 1'b1;
          shreg_d = mem_q[rptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        txd_o = 1'b0;
        tmr_d = bit_end ? '0 : tmr_q + TMR_W'(1);
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        txd_o = shreg_q[0];
        tmr_d = bit_end ? '0 : tmr_q + TMR_W'(1);
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tmr_d = bit_end ? '0 : tmr_q + TMR_W'(1);
        if (bit_end) begin
          if (fifo_ne) begin
            pop     = 1'b1;
            shreg_d = mem_q[rptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = dbus_wdata_i[7:0];
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      fini_pend_q <= 1'b0;
      fini_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      fini_pend_q <= fini_pend_d;
      fini_q      <= fini_d;
    end
  end

endmodule

// File: tb/tb_mmio_console_ctrl.sv
`timescale 1ns/1ps
// Bench for mmio_console_ctrl: CPU stores are scheduled into a frame timeline model
// (start = max(accept+1, line free)); line, busy and finish are compared every cycle.
module tb_mmio_console_ctrl;
  localparam int BIT_CYC = 100;
  localparam int DEPTH   = 16;
  localparam int FRAME   = 10 * BIT_CYC;
  localparam logic [31:0] FINI     = 32'h0002_0000;
  localparam logic [31:0] CON_ADDR = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] dbus_addr_i = '0;
  logic        dbus_wvalid_i = 1'b0;
  logic [31:0] dbus_wdata_i = '0;
  logic        stall_o, txd_o, busy_o, fini_o;

  mmio_console_ctrl #(
    .CLK_FREQ_HZ(100_000_000),
    .BAUD       (1_000_000),
    .FIFO_DEPTH (DEPTH),
    .FINI_CODE  (FINI)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .dbus_addr_i  (dbus_addr_i),
    .dbus_wvalid_i(dbus_wvalid_i),
    .dbus_wdata_i (dbus_wdata_i),
    .stall_o      (stall_o),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .fini_o       (fini_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         acc;
    int         start;
    logic [7:0] b;
  } frame_t;

  frame_t frames[$];
  int tx_free   = 0;
  int fini_edge = -1;
  int fr_rd     = 0;
  int rx_rd     = 0;
  int n_tests   = 0;
  int n_fail    = 0;

  function automatic int exp_count(int c);
    int n = 0;
    foreach (frames[i]) if (frames[i].acc <= c && frames[i].start > c) n++;
    return n;
  endfunction

  function automatic logic exp_busy(int c);
    foreach (frames[i]) if (frames[i].acc <= c && c < frames[i].start + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_txd(int c);
    int k;
    foreach (frames[i]) begin
      if (c >= frames[i].start && c < frames[i].start + FRAME) begin
        k = (c - frames[i].start) / BIT_CYC;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return frames[i].b[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_fini(int c);
    if (fini_edge < 0) return 1'b0;
    return c >= ((fini_edge > tx_free) ? fini_edge : tx_free) + 1;
  endfunction

  function automatic logic fini_pending(int c);
    return fini_edge >= 0 && c >= fini_edge;
  endfunction

  // Per-cycle line/status comparison against the timeline model.
  bit armed = 1'b0;
  int err_txd = 0, err_busy = 0, err_fini = 0;
  always @(negedge rst_n) armed = 1'b1;
  always @(negedge clk_i) begin
    if (armed) begin
      if (txd_o !== exp_txd(cyc))   err_txd++;
      if (busy_o !== exp_busy(cyc)) err_busy++;
      if (fini_o !== exp_fini(cyc)) err_fini++;
    end
  end

  // Independent UART receiver sampling mid-bit.
  logic [7:0] rx_q[$];
  int         rx_t0_q[$];
  bit         rx_ok_q[$];
  bit         rx_act = 1'b0;
  int         rx_t0 = 0, rx_t = 0;
  logic [9:0] rx_sh = '0;
  always @(negedge clk_i) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (txd_o === 1'b0) begin
        rx_act = 1'b1;
        rx_t0  = cyc;
      end
    end else begin
      rx_t = cyc - rx_t0;
      if (rx_t % BIT_CYC == BIT_CYC / 2) begin
        rx_sh[rx_t / BIT_CYC] = txd_o;
        if (rx_t / BIT_CYC == 9) begin
          rx_q.push_back(rx_sh[8:1]);
          rx_t0_q.push_back(rx_t0);
          rx_ok_q.push_back(rx_sh[9] & ~rx_sh[0]);
          rx_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_accept(input logic [31:0] addr, input logic [31:0] data, input int e);
    frame_t f;
    if (!addr[31]) return;
    if (data == FINI) begin
      if (fini_edge < 0) fini_edge = e;
      return;
    end
    if (fini_pending(e - 1)) return;
    f.acc   = e;
    f.start = (e + 1 > tx_free) ? e + 1 : tx_free;
    f.b     = data[7:0];
    tx_free = f.start + FRAME;
    frames.push_back(f);
  endtask

  task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data,
                           output int acc, output int stalls);
    int   c;
    logic want_stall;
    bit   done = 1'b0;
    acc    = -1;
    stalls = 0;
    dbus_addr_i   = addr;
    dbus_wdata_i  = data;
    dbus_wvalid_i = 1'b1;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk_i);
      c = cyc;
      want_stall = addr[31] && (data != FINI) && !fini_pending(c) && (exp_count(c) == DEPTH);
      chk("stall", stall_o, want_stall);
      @(posedge clk_i);
      if (!stall_o) begin
        done = 1'b1;
        acc  = c + 1;
        model_accept(addr, data, c + 1);
      end else begin
        stalls++;
      end
    end
    if (!done) chk("store_accept_timeout", acc, 0);
    #1;
    dbus_wvalid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_drain();
    int i = 0;
    do begin
      @(posedge clk_i);
      #1;
      i++;
    end while ((cyc <= tx_free + 5) && i < 30000);
  endtask

  task automatic check_rx();
    while (rx_rd < rx_q.size()) begin
      if (fr_rd < frames.size()) begin
        chk("rx_byte", rx_q[rx_rd], frames[fr_rd].b);
        chk("rx_start_cycle", rx_t0_q[rx_rd], frames[fr_rd].start);
        chk("rx_framing", rx_ok_q[rx_rd], 1);
        fr_rd++;
      end else begin
        chk("rx_frame_count", fr_rd + 1, frames.size());
      end
      rx_rd++;
    end
  endtask

  int base_txd = 0, base_busy = 0, base_fini = 0;
  task automatic phase_check(input string tag);
    check_rx();
    chk({tag, "_frames"}, fr_rd, frames.size());
    chk({tag, "_txd_wave_err"}, err_txd - base_txd, 0);
    chk({tag, "_busy_err"}, err_busy - base_busy, 0);
    chk({tag, "_fini_err"}, err_fini - base_fini, 0);
    base_txd  = err_txd;
    base_busy = err_busy;
    base_fini = err_fini;
  endtask

  task automatic model_clear();
    check_rx();
    frames.delete();
    fr_rd     = 0;
    tx_free   = 0;
    fini_edge = -1;
  endtask

  task automatic do_reset(input int n);
    model_clear();
    rst_n = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
  endtask

  int acc, st, k, gaps, rx_base, f, last_t0, tgt, bit_k;
  bit seen_stall;
  logic [31:0] a, d;
  logic [7:0]  bytes5 [5];

  initial begin
    #2;
    do_reset(5);
    chk("rst_txd", txd_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_fini", fini_o, 0);
    chk("rst_stall", stall_o, 0);
    idle(50);
    phase_check("idle");

    // Single byte 'A'
    rx_base = rx_q.size();
    cpu_store(CON_ADDR, 32'h41, acc, st);
    chk("b1_stalls", st, 0);
    wait_drain();
    chk("b1_rx_count", rx_q.size() - rx_base, 1);
    if (rx_q.size() > rx_base) chk("b1_latency", rx_t0_q[rx_base] - acc, 1);
    phase_check("single");

    // Random stores, some outside the window, random gaps
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      a[31] = ($urandom_range(0, 4) != 0);
      d = $urandom;
      if (d == FINI) d ^= 32'h1;
      cpu_store(a, d, acc, st);
      idle($urandom_range(0, 600));
    end
    wait_drain();
    phase_check("random");

    // Fill and backpressure: 'a'..'t' back to back
    rx_base = rx_q.size();
    k = 0;
    seen_stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cpu_store(CON_ADDR, 32'h61 + i, acc, st);
      if (st != 0) seen_stall = 1'b1;
      if (!seen_stall) k++;
    end
    chk("fill_nostall_stores", k, 17);
    wait_drain();
    chk("fill_rx_count", rx_q.size() - rx_base, 20);
    if (rx_q.size() >= rx_base + 20) begin
      chk("fill_span", rx_t0_q[rx_base + 19] + FRAME - rx_t0_q[rx_base], 20 * FRAME);
      gaps = 0;
      for (int i = rx_base; i < rx_base + 19; i++)
        if (rx_t0_q[i+1] - rx_t0_q[i] != FRAME) gaps++;
      chk("fill_gaps", gaps, 0);
      chk("fill_last_byte", rx_q[rx_base + 19], 8'h74);
    end
    phase_check("fill");

    // Finish drain: "hi" then finish code
    cpu_store(CON_ADDR, 32'h68, acc, st);
    cpu_store(CON_ADDR, 32'h69, acc, st);
    cpu_store(CON_ADDR, FINI, acc, st);
    chk("fin_store_stall", st, 0);
    f = -1;
    for (int i = 0; i < 5000 && f < 0; i++) begin
      @(negedge clk_i);
      if (fini_o) f = cyc;
    end
    @(posedge clk_i);
    #1;
    last_t0 = (rx_t0_q.size() > 0) ? rx_t0_q[rx_t0_q.size() - 1] : -100000;
    chk("fini_rise", f, last_t0 + FRAME + 1);
    for (int i = 0; i < 3; i++) begin
      cpu_store(CON_ADDR, {24'h0, 8'($urandom)}, acc, st);
      chk("post_fini_stalls", st, 0);
    end
    idle(1500);
    chk("fini_sticky", fini_o, 1);
    phase_check("finish");

    // Ignored address and finish with nothing buffered
    do_reset(3);
    chk("rst2_fini", fini_o, 0);
    cpu_store(32'h0000_1000, 32'h41, acc, st);
    chk("ignored_stall", st, 0);
    idle(1200);
    cpu_store(CON_ADDR, FINI, acc, st);
    f = -1;
    for (int i = 0; i < 50 && f < 0; i++) begin
      @(negedge clk_i);
      if (fini_o) f = cyc;
    end
    @(posedge clk_i);
    #1;
    chk("fini_direct", f, acc + 1);
    phase_check("edge");

    // Reset in the middle of byte 3 of 5, during a low data bit
    do_reset(3);
    bit_k = $urandom_range(0, 7);
    for (int i = 0; i < 5; i++) bytes5[i] = 8'($urandom);
    bytes5[2][bit_k] = 1'b0;
    for (int i = 0; i < 5; i++) cpu_store(CON_ADDR, {24'h0, bytes5[i]}, acc, st);
    tgt = (frames.size() > 2) ? frames[2].start + (1 + bit_k) * BIT_CYC
                                + $urandom_range(0, BIT_CYC - 1) : cyc + 1;
    do begin
      @(posedge clk_i);
      #1;
    end while (cyc < tgt);
    #1;
    chk("midrst_txd_before", txd_o, 0);
    check_rx();
    chk("midrst_frames_before", fr_rd, 2);
    model_clear();
    rst_n = 1'b0;
    #1;
    chk("midrst_txd_now", txd_o, 1);
    chk("midrst_busy_now", busy_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk("midrst_busy_after", busy_o, 0);
    idle(3000);
    phase_check("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
